// File: rtl/mdt_word_injector.sv
// Host-side AGC monitor word injector.
// Accepts one 16-bit word per valid/ready handshake and drives it onto the MDT
// lines during a chosen window of the AGC's MT01..MT12 time pulses, then
// reports OK, ABORT (MGOJAM) or TIMEOUT (no target pulse within N MCTs).
// Ports:
//   SIM_CLK, SIM_RST   clock and synchronous active-high reset
//   MT[11:0]           MT12..MT01 one-hot time pulses from the AGC
//   MGOJAM             AGC GOJAM monitor; aborts any transfer in flight
//   wr_valid/wr_data   host word offer; wr_ready accepts it (IDLE, no GOJAM)
//   MDT[15:0]          MDT16..MDT01 injection bus
//   busy, done, status transfer in progress, end pulse, result code
module mdt_word_injector #(
  parameter int unsigned TARGET_TP   = 7,
  parameter int unsigned HOLD_TP     = 1,
  parameter int unsigned TIMEOUT_MCT = 16
) (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic [11:0] MT,
  input  logic        MGOJAM,
  input  logic        wr_valid,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  output logic [15:0] MDT,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status
);

  localparam int unsigned MT_W   = 12;
  localparam int unsigned TP_W   = 4;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 8;

  // Window end never wraps past TP12.
  localparam int unsigned HI_RAW = TARGET_TP + HOLD_TP - 1;
  localparam logic [TP_W-1:0]  TP_LO  = TP_W'(TARGET_TP);
  localparam logic [TP_W-1:0]  TP_HI  = (HI_RAW > MT_W) ? TP_W'(MT_W) : TP_W'(HI_RAW);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_MCT);

  localparam logic [1:0] RES_OK      = 2'b00;
  localparam logic [1:0] RES_ABORT   = 2'b01;
  localparam logic [1:0] RES_TIMEOUT = 2'b10;

  if (TARGET_TP < 1 || TARGET_TP > 12) begin : g_bad_target
    $error("mdt_word_injector: TARGET_TP must be 1..12");
  end
  if (HOLD_TP < 1 || HOLD_TP > 12) begin : g_bad_hold
    $error("mdt_word_injector: HOLD_TP must be 1..12");
  end
  if (TIMEOUT_MCT < 1 || TIMEOUT_MCT > 255) begin : g_bad_timeout
    $error("mdt_word_injector: TIMEOUT_MCT must be 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state, state_d;
  logic [WORD_W-1:0]   word, word_d;
  logic [WORD_W-1:0]   mdt_d;
  logic [1:0]          status_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [MT_W-1:0]     mt_q, mt_q_d;
  logic [TP_W-1:0]     tp;
  logic                rise_tgt, rise_12, in_window;

  // Free-running MT sampler; only edges seen after a transfer matter.
  always_ff @(posedge SIM_CLK) begin
    mt_q   <= MT;
    mt_q_d <= mt_q;
  end

  // Current time pulse number; zero for no pulse or an overlap glitch.
  always_comb begin
    tp = '0;
    if ($onehot(mt_q)) begin
      for (int i = 0; i < MT_W; i++) begin
        if (mt_q[i]) tp = TP_W'(i + 1);
      end
    end
  end

  assign rise_tgt  = mt_q[TARGET_TP-1] & ~mt_q_d[TARGET_TP-1];
  assign rise_12   = mt_q[MT_W-1] & ~mt_q_d[MT_W-1];
  assign in_window = (tp >= TP_LO) && (tp <= TP_HI);

  assign wr_ready = (state == ST_IDLE) && !MGOJAM;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  // State register and registered MDT/status.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state  <= ST_IDLE;
      word   <= '0;
      MDT    <= '0;
      status <= RES_OK;
      cnt    <= '0;
    end else begin
      state  <= state_d;
      word   <= word_d;
      MDT    <= mdt_d;
      status <= status_d;
      cnt    <= cnt_d;
    end
  end

  // Next-state and output logic. GOJAM outranks target and timeout events,
  // and a target rise outranks an MT12 rise on the same cycle.
  always_comb begin
    state_d  = state;
    word_d   = word;
    mdt_d    = MDT;
    status_d = status;
    cnt_d    = cnt;
    case (state)
      ST_IDLE: begin
        if (wr_valid && wr_ready) begin
          word_d  = wr_data;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (MGOJAM) begin
          state_d  = ST_DONE;
          mdt_d    = '0;
          status_d = RES_ABORT;
        end else if (rise_tgt) begin
          state_d = ST_DRIVE;
          mdt_d   = word;
        end else if (rise_12) begin
          if (cnt != '1) cnt_d = cnt + CNT_W'(1);
          if (cnt_d >= TO_CNT) begin
            state_d  = ST_DONE;
            status_d = RES_TIMEOUT;
          end
        end
      end
      ST_DRIVE: begin
        if (MGOJAM) begin
          state_d  = ST_DONE;
          mdt_d    = '0;
          status_d = RES_ABORT;
        end else if (!in_window) begin
          state_d  = ST_DONE;
          mdt_d    = '0;
          status_d = RES_OK;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
